// File: rtl/tbman.sv
// ---------------------------------------------------------------------------
// tbman -- testbench manager peripheral
//
// Memory-mapped block that a CPU under test uses to report its result,
// exposes a free-running cycle counter, enforces a global timeout and
// (optionally) buffers console characters in a small PUTC FIFO.
//
// Register map (byte offsets, addr[1:0] ignored):
//   0x0 STATUS  R: {24'd0, fifo_count[4:0], overflow, timeout, test_done}
//               W: bit0 = 1 clears CYCLE and the overflow flag
//   0x4 CYCLE   R: cycle counter (value before this cycle's increment)
//   0x8 RESULT  R: stored result code   W: ends the test, 0 = pass
//   0xC PUTC    R: 0                    W: push write_data[7:0] to the FIFO
//
// Build option: define TBMAN_PUTC_EN to implement the PUTC FIFO and its
// valid/ready handshake. Without it PUTC writes are discarded, the FIFO
// outputs are tied low and STATUS reports an empty, non-overflowed FIFO.
// ---------------------------------------------------------------------------
module tbman #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000,
    parameter int          FIFO_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_tbman_n,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data_tbman,
    output logic        test_done,
    output logic        test_pass,
    output logic        putc_valid,
    output logic [7:0]  putc_data,
    input  logic        putc_ready
);

    // Register selects taken from addr[3:2]
    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_CYCLE  = 2'd1;
    localparam logic [1:0] REG_RESULT = 2'd2;
    localparam logic [1:0] REG_PUTC   = 2'd3;

    // Cycle value on which the running test is declared timed out
    localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 32'd1;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DONE    = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Bus decode
    // -----------------------------------------------------------------------
    logic       bus_rd;
    logic       bus_wr;
    logic [1:0] reg_sel;
    logic       result_wr;
    logic       status_clr;
    logic       unused_addr;

    assign bus_rd      = ~cs_tbman_n & ~we;
    assign bus_wr      = ~cs_tbman_n &  we;
    assign reg_sel     = addr[3:2];
    assign result_wr   = bus_wr & (reg_sel == REG_RESULT);
    assign status_clr  = bus_wr & (reg_sel == REG_STATUS) & write_data[0];
    // Byte lanes inside a word are not decoded
    assign unused_addr = ^addr[1:0];

    // -----------------------------------------------------------------------
    // Test-status FSM
    // -----------------------------------------------------------------------
    state_t      state_q;
    state_t      state_d;
    logic [31:0] cycle_q;
    logic [31:0] cycle_d;
    logic [31:0] result_q;
    logic        timeout_hit;
    logic        timeout_flag;
    logic        running;

    assign running     = (state_q == ST_RUN);
    assign timeout_hit = (cycle_q == TIMEOUT_LAST);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a result write beats a coincident timeout; DONE/TIMEOUT hold
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (result_wr) begin
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    state_d = ST_TIMEOUT;
                end
            end
            ST_DONE:    state_d = ST_DONE;
            ST_TIMEOUT: state_d = ST_TIMEOUT;
            default:    state_d = ST_RUN;
        endcase
    end

    // FSM outputs: pass only when the test ended through a zero result code
    always_comb begin
        test_done    = 1'b0;
        test_pass    = 1'b0;
        timeout_flag = 1'b0;
        case (state_q)
            ST_DONE: begin
                test_done = 1'b1;
                test_pass = (result_q == 32'd0);
            end
            ST_TIMEOUT: begin
                test_done    = 1'b1;
                timeout_flag = 1'b1;
            end
            default: begin
                test_done    = 1'b0;
                test_pass    = 1'b0;
                timeout_flag = 1'b0;
            end
        endcase
    end

    // Result code is captured only by the write that ends the test
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= 32'd0;
        end else if (running && result_wr) begin
            result_q <= write_data;
        end
    end

    // Cycle counter: counts while running, wraps naturally, software clear wins
    always_comb begin
        cycle_d = cycle_q;
        if (status_clr) begin
            cycle_d = 32'd0;
        end else if (running) begin
            cycle_d = cycle_q + 32'd1;
        end
    end

    // Cycle counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q <= 32'd0;
        end else begin
            cycle_q <= cycle_d;
        end
    end

    // -----------------------------------------------------------------------
    // PUTC FIFO
    // -----------------------------------------------------------------------
    logic [4:0] fifo_count;
    logic       ovf_flag;

`ifdef TBMAN_PUTC_EN
    localparam int         PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [4:0]       count_q;
    logic [4:0]       count_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             putc_wr;
    logic             fifo_full;
    logic             pop;
    logic             push_ok;

    assign putc_wr   = bus_wr & (reg_sel == REG_PUTC);
    assign fifo_full = (count_q == DEPTH_C);
    assign pop       = putc_valid & putc_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push_ok   = putc_wr & (~fifo_full | pop);

    // Character storage; contents are meaningless while count is zero
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= write_data[7:0];
        end
    end

    // Pointers advance modulo the power-of-two depth
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Occupancy and sticky overflow next-state
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (status_clr) begin
            ovf_d = 1'b0;
        end else if (putc_wr && !push_ok) begin
            ovf_d = 1'b1;
        end
    end

    // Occupancy and overflow registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 5'd0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign putc_valid = (count_q != 5'd0);
    // Head is shown only while valid so an empty FIFO presents zero
    assign putc_data  = putc_valid ? fifo_mem[rd_ptr_q] : 8'd0;
    assign fifo_count = count_q;
    assign ovf_flag   = ovf_q;
`else
    logic unused_putc_ready;

    assign putc_valid        = 1'b0;
    assign putc_data         = 8'd0;
    assign fifo_count        = 5'd0;
    assign ovf_flag          = 1'b0;
    assign unused_putc_ready = putc_ready;
`endif

    // -----------------------------------------------------------------------
    // Registered read port
    // -----------------------------------------------------------------------
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    // Read mux samples pre-update register values; idle cycles hold the data
    always_comb begin
        rdata_d = rdata_q;
        if (bus_rd) begin
            case (reg_sel)
                REG_STATUS: rdata_d = {24'd0, fifo_count, ovf_flag, timeout_flag, test_done};
                REG_CYCLE:  rdata_d = cycle_q;
                REG_RESULT: rdata_d = result_q;
                REG_PUTC:   rdata_d = 32'd0;
                default:    rdata_d = 32'd0;
            endcase
        end
    end

    // Read data register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= 32'd0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign read_data_tbman = rdata_q;

endmodule

// File: tb/tb_tbman.sv
// ---------------------------------------------------------------------------
// tb_tbman -- self-checking bench for tbman.
// Directed scenarios plus randomized bus traffic checked cycle by cycle
// against a queue-based reference model. Define TBMAN_PUTC_EN for both the
// design and this file to exercise the PUTC FIFO.
// ---------------------------------------------------------------------------
module tb_tbman;

    localparam int T     = 24;
    localparam int DEPTH = 4;
`ifdef TBMAN_PUTC_EN
    localparam bit PUTC_EN = 1'b1;
`else
    localparam bit PUTC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs_n = 1'b1;
    logic        we = 1'b0;
    logic [3:0]  addr = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic        ready = 1'b0;
    logic [31:0] rdata;
    logic        done;
    logic        pass;
    logic        pvalid;
    logic [7:0]  pdata;

    tbman #(.TIMEOUT_CYCLES(32'(T)), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .cs_tbman_n(cs_n),
        .we(we),
        .addr(addr),
        .write_data(wdata),
        .read_data_tbman(rdata),
        .test_done(done),
        .test_pass(pass),
        .putc_valid(pvalid),
        .putc_data(pdata),
        .putc_ready(ready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    logic [31:0] m_cycle;
    logic [31:0] m_result;
    logic [31:0] m_rdata;
    bit          m_done, m_pass, m_timeout, m_ovf;
    logic [7:0]  m_q[$];

    function automatic logic [31:0] m_read(input logic [3:0] a);
        logic [31:0] v;
        case (a[3:2])
            2'd0:    v = {24'd0, 5'(m_q.size()), m_ovf, m_timeout, m_done};
            2'd1:    v = m_cycle;
            2'd2:    v = m_result;
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] m_head();
        logic [7:0] h;
        h = (m_q.size() != 0) ? m_q[0] : 8'd0;
        return h;
    endfunction

    task automatic model_reset();
        m_cycle = 0; m_result = 0; m_rdata = 0;
        m_done = 0; m_pass = 0; m_timeout = 0; m_ovf = 0;
        m_q.delete();
    endtask

    // Applies one clock of the driven bus inputs to the model
    task automatic model_step();
        bit rd, wr, pop, running;
        int sz;
        rd = !cs_n && !we;
        wr = !cs_n && we;
        sz = m_q.size();
        pop = PUTC_EN && sz > 0 && ready;
        running = !m_done;
        if (rd) m_rdata = m_read(addr);
        if (pop) void'(m_q.pop_front());
        if (PUTC_EN && wr && addr[3:2] == 2'd3) begin
            if (sz < DEPTH || pop) m_q.push_back(wdata[7:0]);
            else m_ovf = 1;
        end
        if (running) begin
            if (wr && addr[3:2] == 2'd2) begin
                m_done = 1; m_pass = (wdata == 0); m_result = wdata;
            end else if (m_cycle == 32'(T - 1)) begin
                m_done = 1; m_timeout = 1; m_pass = 0;
            end
        end
        if (wr && addr[3:2] == 2'd0 && wdata[0]) begin
            m_cycle = 0; m_ovf = 0;
        end else if (running) begin
            m_cycle = m_cycle + 1;
        end
    endtask

    // ---------------- bus driving ----------------
    task automatic cyc(input bit c_n, input bit w, input logic [3:0] a, input logic [31:0] d);
        cs_n = c_n; we = w; addr = a; wdata = d;
        if (!c_n)
            $display("[TB] t=%0t %s addr=0x%h data=0x%h", $time, w ? "WR" : "RD", a, d);
        model_step();
        @(posedge clk);
        #1;
        cs_n = 1'b1; we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic rd(input logic [3:0] a);
        cyc(1'b0, 1'b0, a, 32'd0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        cyc(1'b0, 1'b1, a, d);
    endtask

    task automatic do_reset();
        reset = 1'b1; cs_n = 1'b1; we = 1'b0; ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        idle(5);
        rd(4'h4);
        if (PUTC_EN) wr(4'hC, 32'h5A);
        // asynchronous assertion mid-period
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (rdata !== 32'd0 || done !== 1'b0 || pass !== 1'b0 || pvalid !== 1'b0 || pdata !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_async: rdata=%h done=%b pass=%b pv=%b pd=%h required all zero",
                     rdata, done, pass, pvalid, pdata);
        end
        do_reset();
        rd(4'h0);
        n_tests++;
        if (rdata !== 32'd0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: rdata=%h done=%b required 0 0", rdata, done);
        end
    endtask

    task automatic test_cycle_read();
        do_reset();
        n_tests++;
        if (done !== 1'b0 || pass !== 1'b0) begin
            n_fail++;
            $display("FAIL cycle_reset_flags: done=%b pass=%b required 0 0", done, pass);
        end
        idle(10);
        rd(4'h4);
        n_tests++;
        if (rdata !== 32'd10 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL cycle_read: rdata=%0d done=%b required 10 0", rdata, done);
        end
        idle(2);
        n_tests++;
        if (rdata !== 32'd10) begin
            n_fail++;
            $display("FAIL read_hold: rdata=%0d required 10", rdata);
        end
        rd(4'h5);
        n_tests++;
        if (rdata !== 32'd13) begin
            n_fail++;
            $display("FAIL cycle_read_lowbits: rdata=%0d required 13", rdata);
        end
    endtask

    task automatic test_result();
        do_reset();
        idle(2);
        wr(4'h8, 32'd0);
        n_tests++;
        if (done !== 1'b1 || pass !== 1'b1) begin
            n_fail++;
            $display("FAIL result_pass: done=%b pass=%b required 1 1", done, pass);
        end
        wr(4'h8, 32'd5);
        rd(4'h8);
        n_tests++;
        if (rdata !== 32'd0 || pass !== 1'b1) begin
            n_fail++;
            $display("FAIL result_absorb: rdata=%0d pass=%b required 0 1", rdata, pass);
        end
        do_reset();
        wr(4'h8, 32'd7);
        rd(4'h8);
        n_tests++;
        if (rdata !== 32'd7 || done !== 1'b1 || pass !== 1'b0) begin
            n_fail++;
            $display("FAIL result_fail: rdata=%0d done=%b pass=%b required 7 1 0", rdata, done, pass);
        end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        n = 0;
        while (!done && n < T + 8) begin
            idle(1);
            n++;
        end
        n_tests++;
        if (n !== T) begin
            n_fail++;
            $display("FAIL timeout_cycle: done after %0d cycles required %0d", n, T);
        end
        rd(4'h0);
        n_tests++;
        if (rdata !== 32'h3 || pass !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_status: status=%h pass=%b required 00000003 0", rdata, pass);
        end
        idle(3);
        rd(4'h4);
        n_tests++;
        if (rdata !== 32'(T)) begin
            n_fail++;
            $display("FAIL cycle_freeze: cycle=%0d required %0d", rdata, T);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        idle(T - 1);
        wr(4'h8, 32'd0);
        n_tests++;
        if (done !== 1'b1 || pass !== 1'b1) begin
            n_fail++;
            $display("FAIL same_cycle_pass: done=%b pass=%b required 1 1", done, pass);
        end
        rd(4'h0);
        n_tests++;
        if (rdata !== 32'h1) begin
            n_fail++;
            $display("FAIL same_cycle_status: status=%h required 00000001", rdata);
        end
    endtask

    task automatic test_status_clear();
        do_reset();
        idle(6);
        wr(4'h0, 32'h1);
        rd(4'h4);
        n_tests++;
        if (rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL status_clear: cycle=%0d required 0", rdata);
        end
        wr(4'h0, 32'hE);
        rd(4'h4);
        n_tests++;
        if (rdata !== 32'd2) begin
            n_fail++;
            $display("FAIL status_noclear: cycle=%0d required 2", rdata);
        end
    endtask

`ifdef TBMAN_PUTC_EN
    task automatic test_putc();
        logic [7:0] chars[5];
        chars = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(4'hC, {24'd0, chars[i]});
        rd(4'h0);
        n_tests++;
        if (rdata !== 32'h24) begin
            n_fail++;
            $display("FAIL putc_full_status: status=%h required 00000024", rdata);
        end
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (pvalid !== 1'b1 || pdata !== chars[i]) begin
                n_fail++;
                $display("FAIL putc_drain%0d: pv=%b pd=%h required 1 %h", i, pvalid, pdata, chars[i]);
            end
            idle(1);
        end
        n_tests++;
        if (pvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL putc_empty: pv=%b required 0", pvalid);
        end
        // push onto empty FIFO while the sink is ready
        wr(4'hC, 32'h5A);
        n_tests++;
        if (pvalid !== 1'b1 || pdata !== 8'h5A) begin
            n_fail++;
            $display("FAIL putc_empty_push: pv=%b pd=%h required 1 5a", pvalid, pdata);
        end
        ready = 1'b0;
        wr(4'hC, 32'h61); wr(4'hC, 32'h62); wr(4'hC, 32'h63);
        // full FIFO: push and pop together
        ready = 1'b1;
        wr(4'hC, 32'h64);
        ready = 1'b0;
        wr(4'h0, 32'h1);
        rd(4'h0);
        n_tests++;
        if (rdata !== 32'h20 || pdata !== 8'h61) begin
            n_fail++;
            $display("FAIL putc_full_pushpop: status=%h pd=%h required 00000020 61", rdata, pdata);
        end
    endtask
`else
    task automatic test_putc();
        do_reset();
        idle(3);
        rd(4'h4);
        ready = 1'b1;
        wr(4'hC, 32'h41);
        n_tests++;
        if (pvalid !== 1'b0 || pdata !== 8'd0) begin
            n_fail++;
            $display("FAIL putc_disabled: pv=%b pd=%h required 0 00", pvalid, pdata);
        end
        rd(4'h0);
        n_tests++;
        if (rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL putc_disabled_status: status=%h required 00000000", rdata);
        end
        ready = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [3:0]  a;
        logic [31:0] d;
        bit          c, w;
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            for (int i = 0; i < 50; i++) begin
                c = ($urandom_range(0, 2) == 0);
                w = $urandom_range(0, 1);
                a = 4'($urandom_range(0, 15));
                d = (a[3:2] == 2'd2) ? 32'($urandom_range(0, 2)) : $urandom;
                if (a[3:2] == 2'd2 && w && $urandom_range(0, 2) != 0) c = 1'b0;
                if (a[3:2] == 2'd0 && $urandom_range(0, 3) != 0) d[0] = 1'b0;
                ready = ($urandom_range(0, 2) == 0);
                cyc(!c, w, a, d);
                n_tests++;
                if (rdata !== m_rdata || done !== m_done || pass !== m_pass ||
                    pvalid !== (m_q.size() != 0) || pdata !== m_head()) begin
                    n_fail++;
                    $display("FAIL random ep%0d cyc%0d: rdata=%h done=%b pass=%b pv=%b pd=%h required rdata=%h done=%b pass=%b pv=%b pd=%h",
                             ep, i, rdata, done, pass, pvalid, pdata,
                             m_rdata, m_done, m_pass, (m_q.size() != 0), m_head());
                end
            end
        end
        ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cycle_read();
        test_result();
        test_timeout();
        test_same_cycle();
        test_status_clear();
        test_putc();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tbman.md
TBMAN -- requirements
Module: tbman

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 32'd100000: cycle count at which the test is declared timed out.
REQ-002 Parameter FIFO_DEPTH, default 4: PUTC FIFO entries, power of two, 2..16.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cs_tbman_n  input  1  active-low chip select from the address decoder.
REQ-006 we  input  1  write strobe; 1 = write, 0 = read; sampled only when cs_tbman_n = 0.
REQ-007 addr  input  4  byte offset; bits [3:2] select the register, bits [1:0] ignored.
REQ-008 write_data  input  32  store data.
REQ-009 read_data_tbman  output  32  registered read data, consumed by the load-data mux.
REQ-010 test_done  output  1  test finished, by result write or by timeout.
REQ-011 test_pass  output  1  test passed; valid only when test_done = 1.
REQ-012 putc_valid  output  1  FIFO head valid.
REQ-013 putc_data  output  8  FIFO head character.
REQ-014 putc_ready  input  1  sink accepts the head when putc_valid = 1.

Function
REQ-015 Register map: 0x0 STATUS, 0x4 CYCLE, 0x8 RESULT, 0xC PUTC.
REQ-016 A read (cs_tbman_n = 0, we = 0) loads read_data_tbman at the next edge (1-cycle latency); with no read, read_data_tbman holds its value.
REQ-017 STATUS read = {24'd0, fifo_count[4:0], overflow, timeout, test_done}; STATUS write with bit0 = 1 clears CYCLE and overflow; other bits ignored.
REQ-018 CYCLE is a 32-bit up-counter incremented every cycle in RUN state; it wraps 0xFFFFFFFF -> 0, and a read returns the pre-increment value.
REQ-019 FSM states: RUN (after reset), DONE, TIMEOUT.
REQ-020 RUN -> DONE on a RESULT write: test_pass = (write_data == 0), and the code is stored.
REQ-021 RUN -> TIMEOUT when CYCLE == TIMEOUT_CYCLES - 1: test_pass = 0, timeout = 1.
REQ-022 A RESULT write in the same cycle as the timeout condition enters DONE.
REQ-023 DONE and TIMEOUT are absorbing until reset; further RESULT writes are ignored and CYCLE freezes.
REQ-024 test_done = 1 in DONE or TIMEOUT.
REQ-025 RESULT read returns the stored code (0 before any write); PUTC read returns 0.
REQ-026 A PUTC write pushes write_data[7:0] when the FIFO is not full; when full, the data is dropped and sticky overflow is set.
REQ-027 A pop occurs when putc_valid & putc_ready.
REQ-028 Simultaneous push and pop on a full FIFO: push accepted, count unchanged.
REQ-029 Simultaneous push and pop on an empty FIFO: the push lands and putc_valid rises next cycle.
REQ-030 FIFO pointers wrap modulo FIFO_DEPTH; putc_data is stable while putc_valid = 1 and putc_ready = 0.
REQ-031 PUTC writes are accepted in all FSM states.

Reset
REQ-032 Reset (async assert, sync deassert by source) forces:
- state RUN; CYCLE 0; RESULT 0;
- read_data_tbman 0; test_done 0; test_pass 0;
- overflow 0; timeout 0;
- FIFO empty; putc_valid 0; putc_data 0.
REQ-033 Reset mid-operation discards FIFO contents and any in-flight read.

Configuration
REQ-034 Macro TBMAN_PUTC_EN defined: the PUTC FIFO and handshake are implemented as above.
REQ-035 TBMAN_PUTC_EN undefined:
- no FIFO storage; PUTC writes ignored;
- putc_valid = 0, putc_data = 0;
- STATUS fifo_count and overflow read 0; putc_ready ignored.

Verification
REQ-036 Reset, then read 0x4 at cycle 10 -> read_data_tbman = 10 one cycle later; test_done = 0.
REQ-037 Write 0x8 = 0 -> next cycle test_done = 1, test_pass = 1; then write 0x8 = 5 -> read 0x8 returns 0.
REQ-038 TIMEOUT_CYCLES = 20, no writes -> test_done = 1 at cycle 20, test_pass = 0, STATUS = 0x3.
REQ-039 FIFO_DEPTH = 4, putc_ready = 0, write 0xC with 'A','B','C','D','E' -> STATUS fifo_count = 4, overflow = 1; raise putc_ready -> 'A','B','C','D' emitted in order, then putc_valid = 0.
REQ-040 RESULT write in the same cycle as timeout (TIMEOUT_CYCLES = 8, write 0x8 = 0 at cycle 7) -> test_pass = 1, timeout = 0.
REQ-041 TBMAN_PUTC_EN undefined, write 0xC = 0x41 -> putc_valid stays 0, STATUS = 0x0.
